// File: rtl/iso_idle_pattern_gen.sv
// Lockstep DisplayPort idle pattern generator for up to 4 main-link lanes (BS/VBID/MVID/MAUD then FILL).
// Outputs registered, 1 cycle behind the FSM; no backpressure. ISO_IDLE_SR_EN enables periodic SR substitution.
module iso_idle_pattern_gen #(
  parameter int IDLE_PERIOD = 8192,
  parameter int SR_INTERVAL = 512
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] td_lane_count,
  input  logic       sched_idle_en_lane0,
  input  logic       sched_idle_en_lane1,
  input  logic       sched_idle_en_lane2,
  input  logic       sched_idle_en_lane3,
  output logic       idle_activate_en_lane0,
  output logic       idle_activate_en_lane1,
  output logic       idle_activate_en_lane2,
  output logic       idle_activate_en_lane3,
  output logic [7:0] idle_symbol_lane0,
  output logic [7:0] idle_symbol_lane1,
  output logic [7:0] idle_symbol_lane2,
  output logic [7:0] idle_symbol_lane3,
  output logic       idle_k_lane0,
  output logic       idle_k_lane1,
  output logic       idle_k_lane2,
  output logic       idle_k_lane3
);

  localparam int            CW       = $clog2(IDLE_PERIOD);
  localparam logic [CW-1:0] CNT_LAST = CW'(IDLE_PERIOD - 1);

  if (IDLE_PERIOD < 8 || IDLE_PERIOD > 65536 || SR_INTERVAL < 1) begin : g_param_check
    $error("iso_idle_pattern_gen: IDLE_PERIOD or SR_INTERVAL out of range");
  end

  typedef enum logic [2:0] {
    ST_OFF,
    ST_BS,
    ST_VBID,
    ST_MVID,
    ST_MAUD,
    ST_FILL
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] sym_cnt;
  logic [3:0]    lane_act;
  logic [3:0]    elig;
  logic [3:0]    elig_en;
  logic          any_en;
  logic          bs_entry;
  logic [7:0]    bs_sym;
  logic [7:0]    seq_sym;
  logic          seq_k;
  logic [7:0]    sym_q [4];
  logic [3:0]    k_q;
  logic [3:0]    act_q;

  always_comb begin
    elig = 4'b1111;
    case (td_lane_count)
      2'b00:   elig = 4'b0001;
      2'b01:   elig = 4'b0011;
      default: elig = 4'b1111;
    endcase
  end

  assign elig_en = elig & {sched_idle_en_lane3, sched_idle_en_lane2,
                           sched_idle_en_lane1, sched_idle_en_lane0};
  assign any_en  = |elig_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_OFF;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_OFF:  if (any_en) state_nxt = ST_BS;
      ST_BS:   state_nxt = ST_VBID;
      ST_VBID: state_nxt = ST_MVID;
      ST_MVID: state_nxt = ST_MAUD;
      ST_MAUD: state_nxt = any_en ? ST_FILL : ST_OFF;
      ST_FILL: begin
        if (!any_en)                 state_nxt = ST_OFF;
        else if (sym_cnt == CNT_LAST) state_nxt = ST_BS;
      end
      default: state_nxt = ST_OFF;
    endcase
  end

  // BS lasts exactly one cycle, so the next state alone identifies a BS entry.
  assign bs_entry = (state_nxt == ST_BS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               sym_cnt <= '0;
    else if (bs_entry || state_nxt == ST_OFF) sym_cnt <= '0;
    else                                      sym_cnt <= sym_cnt + 1'b1;
  end

  // Membership is re-latched at every BS; in FILL a dropped enable retires the lane at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    lane_act <= '0;
    else if (bs_entry)             lane_act <= elig_en;
    else if (state_nxt == ST_OFF)  lane_act <= '0;
    else if (state == ST_FILL)     lane_act <= lane_act & elig_en;
    else                           lane_act <= lane_act & elig;
  end

`ifdef ISO_IDLE_SR_EN
  localparam int            SW      = (SR_INTERVAL > 1) ? $clog2(SR_INTERVAL) : 1;
  localparam logic [SW-1:0] SR_LAST = SW'(SR_INTERVAL - 1);

  logic [SW-1:0] sr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        sr_cnt <= '0;
    else if (bs_entry && state == ST_OFF) sr_cnt <= '0;
    else if (bs_entry)                 sr_cnt <= (sr_cnt == SR_LAST) ? '0 : sr_cnt + 1'b1;
  end

  assign bs_sym = (sr_cnt == '0) ? 8'h1C : 8'hBC;
`else
  assign bs_sym = 8'hBC;
`endif

  always_comb begin
    seq_sym = 8'h00;
    seq_k   = 1'b0;
    case (state)
      ST_BS: begin
        seq_sym = bs_sym;
        seq_k   = 1'b1;
      end
      ST_VBID: seq_sym = 8'h09;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) sym_q[i] <= 8'h00;
      k_q   <= '0;
      act_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        sym_q[i] <= lane_act[i] ? seq_sym : 8'h00;
        k_q[i]   <= lane_act[i] & seq_k;
        act_q[i] <= lane_act[i] & (state == ST_FILL);
      end
    end
  end

  assign idle_symbol_lane0      = sym_q[0];
  assign idle_symbol_lane1      = sym_q[1];
  assign idle_symbol_lane2      = sym_q[2];
  assign idle_symbol_lane3      = sym_q[3];
  assign idle_k_lane0           = k_q[0];
  assign idle_k_lane1           = k_q[1];
  assign idle_k_lane2           = k_q[2];
  assign idle_k_lane3           = k_q[3];
  assign idle_activate_en_lane0 = act_q[0];
  assign idle_activate_en_lane1 = act_q[1];
  assign idle_activate_en_lane2 = act_q[2];
  assign idle_activate_en_lane3 = act_q[3];

endmodule

// File: tb/tb_iso_idle_pattern_gen.sv
// Bench for iso_idle_pattern_gen: directed vector table, BS spacing/reset sequences, randomized run vs positional model.
module tb_iso_idle_pattern_gen;

  localparam int P   = 16;
  localparam int SRI = 4;
`ifdef ISO_IDLE_SR_EN
  localparam bit         SR_ON    = 1'b1;
  localparam logic [7:0] FIRST_BS = 8'h1C;
`else
  localparam bit         SR_ON    = 1'b0;
  localparam logic [7:0] FIRST_BS = 8'hBC;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] td_lane_count;
  logic [3:0] en;
  logic       act0, act1, act2, act3;
  logic [7:0] sym0, sym1, sym2, sym3;
  logic       k0, k1, k2, k3;

  always #5 clk = ~clk;

  iso_idle_pattern_gen #(.IDLE_PERIOD(P), .SR_INTERVAL(SRI)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .td_lane_count          (td_lane_count),
    .sched_idle_en_lane0    (en[0]),
    .sched_idle_en_lane1    (en[1]),
    .sched_idle_en_lane2    (en[2]),
    .sched_idle_en_lane3    (en[3]),
    .idle_activate_en_lane0 (act0),
    .idle_activate_en_lane1 (act1),
    .idle_activate_en_lane2 (act2),
    .idle_activate_en_lane3 (act3),
    .idle_symbol_lane0      (sym0),
    .idle_symbol_lane1      (sym1),
    .idle_symbol_lane2      (sym2),
    .idle_symbol_lane3      (sym3),
    .idle_k_lane0           (k0),
    .idle_k_lane1           (k1),
    .idle_k_lane2           (k2),
    .idle_k_lane3           (k3)
  );

  logic [31:0] got_sym;
  logic [3:0]  got_k, got_act;
  assign got_sym = {sym3, sym2, sym1, sym0};
  assign got_k   = {k3, k2, k1, k0};
  assign got_act = {act3, act2, act1, act0};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] es, input logic [3:0] ek, input logic [3:0] ea);
    n_checks++;
    if (got_sym !== es || got_k !== ek || got_act !== ea) begin
      n_fail++;
      $display("FAIL %s: got sym=%h k=%b act=%b, expected sym=%h k=%b act=%b",
               name, got_sym, got_k, got_act, es, ek, ea);
    end
  endtask

  task automatic fail_check(input string name, input bit ok, input int got, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_bs(input int s);
    return (SR_ON && (s % SRI == 0)) ? 8'h1C : 8'hBC;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] en;
    logic [1:0] lc;
    logic [7:0] sym;
    logic       k;
    logic       act;
    logic [3:0] lanes;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] e, input logic [1:0] lc, input logic [7:0] s,
                     input logic k, input logic a, input logic [3:0] lanes, input int n);
    vec_t v;
    v.en = e; v.lc = lc; v.sym = s; v.k = k; v.act = a; v.lanes = lanes;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  // ---------------- positional reference model ----------------
  bit         m_run;
  int         m_pos;
  int         m_seq;
  logic [3:0] m_act;

  task automatic model_expect(output logic [31:0] es, output logic [3:0] ek, output logic [3:0] ea);
    es = '0; ek = '0; ea = '0;
    for (int i = 0; i < 4; i++) begin
      if (m_run && m_act[i]) begin
        if (m_pos == 0) begin
          es[i*8 +: 8] = exp_bs(m_seq);
          ek[i]        = 1'b1;
        end else if (m_pos == 1) begin
          es[i*8 +: 8] = 8'h09;
        end
        ea[i] = (m_pos >= 4);
      end
    end
  endtask

  task automatic model_step(input logic [3:0] e_in, input logic [1:0] lc);
    int         nl;
    logic [3:0] elig;
    logic [3:0] e;
    nl = (lc == 2'b00) ? 1 : (lc == 2'b01) ? 2 : 4;
    for (int i = 0; i < 4; i++) elig[i] = (i < nl);
    e = e_in & elig;
    if (!m_run) begin
      if (|e) begin
        m_run = 1'b1; m_pos = 0; m_seq = 0; m_act = e;
      end else begin
        m_act = '0;
      end
    end else if (m_pos < 3) begin
      m_pos++;
      m_act = m_act & elig;
    end else if (!(|e)) begin
      m_run = 1'b0;
      m_act = '0;
    end else if (m_pos == P - 1) begin
      m_pos = 0;
      m_seq++;
      m_act = e;
    end else begin
      if (m_pos == 3) m_act = m_act & elig;
      else            m_act = m_act & e;
      m_pos++;
    end
  endtask

  initial begin
    logic [31:0] es;
    logic [3:0]  ek, ea, ren;
    logic [1:0]  rlc;
    int          cnt;
    bit          seen;

    // single lane start, period, then drop on VBID
    add(4'h1, 2'b00, 8'h00,    0, 0, 4'b0000, 1);
    add(4'h1, 2'b00, FIRST_BS, 1, 0, 4'b0001, 1);
    add(4'h1, 2'b00, 8'h09,    0, 0, 4'b0001, 1);
    add(4'h1, 2'b00, 8'h00,    0, 0, 4'b0001, 2);
    add(4'h1, 2'b00, 8'h00,    0, 1, 4'b0001, 12);
    add(4'h1, 2'b00, 8'hBC,    1, 0, 4'b0001, 1);
    add(4'h0, 2'b00, 8'h09,    0, 0, 4'b0001, 1);
    add(4'h0, 2'b00, 8'h00,    0, 0, 4'b0000, 5);
    // two-lane gating with all enables high
    add(4'hF, 2'b01, 8'h00,    0, 0, 4'b0000, 1);
    add(4'hF, 2'b01, FIRST_BS, 1, 0, 4'b0011, 1);
    add(4'hF, 2'b01, 8'h09,    0, 0, 4'b0011, 1);
    add(4'hF, 2'b01, 8'h00,    0, 0, 4'b0011, 2);
    add(4'hF, 2'b01, 8'h00,    0, 1, 4'b0011, 3);
    add(4'h0, 2'b01, 8'h00,    0, 1, 4'b0011, 1);
    add(4'h0, 2'b01, 8'h00,    0, 0, 4'b0000, 2);
    // late join of lane1
    add(4'h1, 2'b01, 8'h00,    0, 0, 4'b0000, 1);
    add(4'h1, 2'b01, FIRST_BS, 1, 0, 4'b0001, 1);
    add(4'h1, 2'b01, 8'h09,    0, 0, 4'b0001, 1);
    add(4'h1, 2'b01, 8'h00,    0, 0, 4'b0001, 1);
    add(4'h3, 2'b01, 8'h00,    0, 0, 4'b0001, 1);
    add(4'h3, 2'b01, 8'h00,    0, 1, 4'b0001, 12);
    add(4'h3, 2'b01, 8'hBC,    1, 0, 4'b0011, 1);
    add(4'h3, 2'b01, 8'h09,    0, 0, 4'b0011, 1);
    add(4'h3, 2'b01, 8'h00,    0, 0, 4'b0011, 2);
    add(4'h3, 2'b01, 8'h00,    0, 1, 4'b0011, 1);
    add(4'h0, 2'b01, 8'h00,    0, 1, 4'b0011, 1);
    add(4'h0, 2'b01, 8'h00,    0, 0, 4'b0000, 1);

    // reset state
    en = 4'h0; td_lane_count = 2'b11;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1 check("reset", 32'h0, 4'h0, 4'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      check($sformatf("idle_quiet%0d", c), 32'h0, 4'h0, 4'h0);
    end

    // table
    for (int v = 0; v < vecs.size(); v++) begin
      en = vecs[v].en; td_lane_count = vecs[v].lc;
      @(posedge clk); #1;
      es = '0; ek = '0; ea = '0;
      for (int i = 0; i < 4; i++) begin
        if (vecs[v].lanes[i]) begin
          es[i*8 +: 8] = vecs[v].sym;
          ek[i]        = vecs[v].k;
          ea[i]        = vecs[v].act;
        end
      end
      check($sformatf("vec%0d", v), es, ek, ea);
    end

    // BS spacing and BS/SR slot symbols over five sequences, four lanes
    en = 4'hF; td_lane_count = 2'b11;
    seen = 0;
    for (int c = 0; c < 5 && !seen; c++) begin
      @(posedge clk); #1;
      if (got_k[0]) seen = 1;
    end
    fail_check("bs_start_timeout", seen, 0, 1);
    for (int s = 0; s < 5; s++) begin
      check($sformatf("bs_slot%0d", s), {4{exp_bs(s)}}, 4'hF, 4'h0);
      if (s < 4) begin
        cnt = 0; seen = 0;
        while (!seen && cnt < P + 4) begin
          @(posedge clk); #1;
          cnt++;
          if (got_k[0]) seen = 1;
        end
        fail_check($sformatf("bs_spacing%0d", s), seen && cnt == P, cnt, P);
      end
    end

    // asynchronous reset in the middle of FILL
    repeat (6) begin @(posedge clk); #1; end
    check("pre_reset_fill", 32'h0, 4'h0, 4'hF);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'h0, 4'h0, 4'h0);
    en = 4'h0;
    @(posedge clk); #1;
    check("held_reset", 32'h0, 4'h0, 4'h0);
    rst_n = 1'b1;

    // randomized run against the model
    m_run = 0; m_pos = 0; m_seq = 0; m_act = '0;
    ren = 4'h0; rlc = 2'b11;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 49) == 0) begin
        ren = 4'($urandom);
      end else if ($urandom_range(0, 39) == 0) begin
        int b;
        b = $urandom_range(0, 3);
        ren[b] = ~ren[b];
      end
      if ($urandom_range(0, 199) == 0) rlc = 2'($urandom);
      en = ren; td_lane_count = rlc;
      model_expect(es, ek, ea);
      model_step(ren, rlc);
      @(posedge clk); #1;
      check($sformatf("rand%0d", c), es, ek, ea);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iso_idle_pattern_gen.md
# iso_idle_pattern_gen

Generates the DisplayPort idle pattern for each main-link lane whenever the isochronous scheduler selects idle on that lane. It consumes `sched_idle_en_lane0..3` and the lane count from the iso control stage. It returns `idle_activate_en_lane0..3` to that stage as the safe-switch indication. Its per-lane symbol outputs feed the lane steering/mux stage ahead of scrambling and 8b/10b encoding.

## Interface
- `IDLE_PERIOD`, default 8192: link symbols per lane from one BS to the next; legal range 8 to 65536.
- `SR_INTERVAL`, default 512: number of idle sequences per scrambler-reset substitution; used only with the macro.
- `clk` in 1: link symbol clock, one symbol per lane per cycle.
- `rst_n` in 1: reset, asynchronous and active-low.
- `td_lane_count` in 2: encoding 2'b00 = 1 lane, 2'b01 = 2 lanes, 2'b11 = 4 lanes; 2'b10 is treated as 4 lanes.
- `sched_idle_en_lane0..3` in 1 each: idle requested on the lane.
- `idle_activate_en_lane0..3` out 1 each: lane is emitting idle and is at a sequence boundary, so switching is safe.
- `idle_symbol_lane0..3` out 8 each: symbol byte.
- `idle_k_lane0..3` out 1 each: symbol is a K-code.

## Operation
- Lane N is eligible when N < active lane count. Enables on ineligible lanes are ignored.
- `any_en` = OR of the eligible enables.
- All lanes run in lockstep from one FSM and one symbol counter `sym_cnt` of width clog2(IDLE_PERIOD).
- FSM states: OFF, BS, VBID, MVID, MAUD, FILL.
  - OFF -> BS when `any_en`=1.
  - BS -> VBID -> MVID -> MAUD: unconditional, one cycle each.
  - MAUD -> FILL when `any_en`=1; MAUD -> OFF otherwise.
  - FILL -> BS when `sym_cnt` = IDLE_PERIOD-1 and `any_en`=1.
  - FILL -> OFF when `any_en`=0, on the next cycle.
- Enable dropped during BS..MAUD: the 4-symbol sequence always completes.
- `sym_cnt`:
  - Cleared to 0 on entry to BS.
  - Increments every cycle outside OFF.
  - Wraps IDLE_PERIOD-1 -> 0 exactly as BS is re-entered.
- Per-lane `lane_act[N]` is latched on every entry to BS from that lane's eligible enable. A lane whose enable rises mid-sequence joins at the next BS.
- A lane whose enable falls while in FILL is deactivated immediately; its outputs go to zero on the next cycle.
- Symbols for active lanes:
  - BS: K28.5 = 8'hBC, k=1.
  - VBID: 8'h09 (vertical blanking, NoVideoStream_Flag), k=0.
  - MVID: 8'h00, k=0.
  - MAUD: 8'h00, k=0.
  - FILL: 8'h00, k=0.
- Inactive lanes, and all lanes in OFF, output 8'h00 with k=0.
- `idle_activate_en_laneN` = `lane_act[N]` AND state==FILL.
- Lane-count change while not in OFF takes effect at the next BS latch. Ineligible lanes are forced inactive immediately.

## Timing
- All outputs are registered.
- Reset values: FSM OFF, `sym_cnt`=0, `lane_act`=0, all symbols 8'h00, all k=0, all `idle_activate_en`=0, SR counter 0.
- Latency: an enable sampled high at edge n while in OFF gives BS on the outputs after edge n+1, i.e. one cycle of latency.
- BS-to-BS spacing in steady state is exactly IDLE_PERIOD cycles.
- `idle_activate_en` rises in the cycle after MAUD and falls on the cycle BS is output.
- `rst_n` asserted mid-sequence: all outputs go to reset values asynchronously. There is no partial-sequence completion.

## Configuration
- `ISO_IDLE_SR_EN` defined:
  - A sequence counter (width clog2(SR_INTERVAL)) increments on each BS entry.
  - When the counter is 0, the BS slot outputs SR = K28.0 = 8'h1C with k=1 instead of BS.
  - The counter resets to 0 on entry from OFF, so the first sequence after idle start is SR.
- `ISO_IDLE_SR_EN` undefined: BS is always 8'hBC and the counter is absent.

## Test plan
- Reset check (IDLE_PERIOD=16, 4 lanes): `rst_n`=0 -> all outputs 0; release, no enables -> outputs stay 0 for 50 cycles.
- Single-lane start: `td_lane_count`=00, `sched_idle_en_lane0` high at cycle 10 -> lane0 shows BC/k1, 09, 00, 00 on cycles 11-14. The next BC appears at cycle 27. `idle_activate_en_lane0` is high during cycles 15-26. Lanes 1-3 stay 0.
- Lane gating: `td_lane_count`=01 with all four enables high -> lanes 0-1 carry identical sequences; lanes 2-3 output 0 and their `idle_activate_en` stays 0.
- Enable drop mid-sequence: deassert on the VBID cycle -> MVID and MAUD still output, then OFF. `idle_activate_en` never rises.
- Late join: lane1 enable rises 3 cycles after lane0's BS (2-lane mode) -> lane1 outputs 0 until the next BS, then runs in lockstep with lane0.
- `ISO_IDLE_SR_EN`, SR_INTERVAL=4, IDLE_PERIOD=16: the first BS slot is 1C/k1 and the next three are BC. The 5th BS slot is 1C.
